// File: rtl/transmitter.sv
// 8N1 serial transmitter with a valid/ready byte interface.
// One frame holds each of its ten bits on tx_out for CLKS_PER_BIT cycles.
module transmitter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_out_q, tx_out_d;
    // Held low through reset so no byte is accepted until one edge after release.
    logic             rdy_q;
    logic             bit_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_out_q <= 1'b1;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_out_q <= tx_out_d;
            rdy_q    <= 1'b1;
        end
    end

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_out_d = tx_out_q;
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                if (tx_valid && tx_ready) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    cnt_d    = '0;
                    idx_d    = '0;
                    tx_out_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    idx_d    = '0;
                    tx_out_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d  = STOP;
                        tx_out_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        tx_out_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    tx_out_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        tx_ready = (state_q == IDLE) && rdy_q;
        tx_busy  = (state_q != IDLE);
        tx_out   = tx_out_q;
    end

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: one instance at CLKS_PER_BIT=4, one at the
// minimum divider of 2, sharing a clock.
module tb_transmitter;

    logic       clk = 1'b0;
    logic       rst_n_a, rst_n_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       rdy_a, out_a, busy_a;
    logic       rdy_b, out_b, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    transmitter #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(rdy_a), .tx_out(out_a), .tx_busy(busy_a)
    );

    transmitter #(.CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(rdy_b), .tx_out(out_b), .tx_busy(busy_b)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // {ready, busy, out} of the selected instance
    function automatic logic [15:0] obs(input bit sel);
        return sel ? {13'd0, rdy_b, busy_b, out_b} : {13'd0, rdy_a, busy_a, out_a};
    endfunction

    // Called at #1 after the accepting edge; ends at #1 after the edge entering IDLE.
    task automatic frame(input string tag, input logic [7:0] b, input int cpb, input bit sel);
        logic [9:0] fb;
        fb = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * cpb; k++) begin
            check($sformatf("%s k=%0d", tag, k), obs(sel), {13'd0, 1'b0, 1'b1, fb[k / cpb]});
            @(posedge clk); #1;
        end
        check($sformatf("%s idle", tag), obs(sel), 16'h5);
    endtask

    initial begin
        rst_n_a = 1'b0; valid_a = 1'b1; data_a = 8'hAA;
        rst_n_b = 1'b0; valid_b = 1'b0; data_b = 8'h00;

        // Reset held 3 cycles with tx_valid high: nothing starts
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", obs(1'b0), 16'h1);
        check("rst_b", obs(1'b1), 16'h1);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(posedge clk); #1;
        check("rel_first_edge", obs(1'b0), 16'h5);
        @(posedge clk); #1;
        valid_a = 1'b0;
        frame("rel_accept", 8'hAA, 4, 1'b0);

        // Single byte 0xA5
        repeat (2) @(posedge clk);
        #1;
        data_a = 8'hA5; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        frame("a5", 8'hA5, 4, 1'b0);

        // Back-to-back 0x00 then 0xFF with tx_valid held
        data_a = 8'h00; valid_a = 1'b1;
        @(posedge clk); #1;
        data_a = 8'hFF;
        frame("b2b_00", 8'h00, 4, 1'b0);
        @(posedge clk); #1;
        valid_a = 1'b0;
        frame("b2b_ff", 8'hFF, 4, 1'b0);

        // Input changes while busy are ignored; 0x3C follows if still valid
        data_a = 8'h81; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        fork
            frame("busy_81", 8'h81, 4, 1'b0);
            begin
                repeat (10) @(posedge clk);
                #2 valid_a = 1'b1; data_a = 8'h99;
                repeat (5) @(posedge clk);
                #2 data_a = 8'h3C;
            end
        join
        @(posedge clk); #1;
        valid_a = 1'b0;
        frame("next_3c", 8'h3C, 4, 1'b0);

        // Reset during data bit 3 aborts the frame
        data_a = 8'h5A; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("pre_abort_busy", {15'd0, busy_a}, 16'h1);
        rst_n_a = 1'b0;
        @(posedge clk); #1;
        check("abort_edge", obs(1'b0), 16'h1);
        rst_n_a = 1'b1;
        @(posedge clk); #1;
        check("abort_rel", obs(1'b0), 16'h5);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort_quiet k=%0d", k), obs(1'b0), 16'h5);
        end

        // Minimum divider: 0x55 at 2 cycles per bit
        data_b = 8'h55; valid_b = 1'b1;
        @(posedge clk); #1;
        valid_b = 1'b0;
        frame("div2_55", 8'h55, 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Parameters
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit period; legal values are 2 or more.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous reset, active-low, sampled on the rising edge of clk.
REQ-004 The block SHALL have port tx_data, input, 8 bits: the byte to send; sampled only on an accepting edge.
REQ-005 The block SHALL have port tx_valid, input, 1 bit: the producer offers tx_data.
REQ-006 The block SHALL have port tx_ready, output, 1 bit: the block can accept a byte.
REQ-007 The block SHALL have port tx_out, output, 1 bit: the serial line; idle high; registered.
REQ-008 The block SHALL have port tx_busy, output, 1 bit: a frame is in progress.

Function
REQ-009 The frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), no parity.
REQ-010 The state machine SHALL have states IDLE, START, DATA and STOP.
REQ-011 tx_ready SHALL equal (state == IDLE); tx_busy SHALL equal (state != IDLE).
REQ-012 An accepting edge SHALL be a rising clk edge with tx_valid=1, tx_ready=1 and rst_n=1.
REQ-013 On an accepting edge, the block SHALL latch tx_data into an internal shift register, go to START, drive tx_out=0 and clear the bit-period counter.
REQ-014 Each bit SHALL be held on tx_out for exactly CLKS_PER_BIT cycles, timed by a counter of width $clog2(CLKS_PER_BIT) that wraps to 0 at CLKS_PER_BIT-1.
REQ-015 START SHALL go to DATA after one bit period, driving bit 0 of the latched byte.
REQ-016 DATA SHALL shift out bits 0..7 in order, using a 3-bit index that increments at each bit-period end.
REQ-017 After bit 7's period, DATA SHALL go to STOP and drive tx_out=1.
REQ-018 After one bit period, STOP SHALL go to IDLE with tx_out=1.
REQ-019 A frame SHALL last exactly 10*CLKS_PER_BIT cycles, measured from the accepting edge to the edge that enters IDLE.
REQ-020 Back-to-back: with tx_valid held high, the next accepting edge SHALL be the first edge after IDLE is entered, giving exactly one idle-high cycle between frames.
REQ-021 tx_data and tx_valid changes while tx_ready=0 SHALL be ignored; the frame in flight SHALL be unaffected.
REQ-022 In IDLE, tx_out SHALL be 1 regardless of the tx_data value.

Reset
REQ-023 On an edge with rst_n=0, the block SHALL set: state=IDLE, tx_out=1, tx_busy=0, bit counter=0, bit index=0, shift register=0.
REQ-024 tx_ready SHALL be 0 while rst_n=0 and 1 on the first edge after release.
REQ-025 Reset mid-frame SHALL abort the frame: tx_out=1 from the reset edge onward, with no resumption or retransmit after release.
REQ-026 tx_valid=1 on an edge with rst_n=0 SHALL NOT be accepted.

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte: send 0xA5 -> tx_out pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_busy high for 40 cycles; tx_ready high on the following cycle.
REQ-028 Back-to-back: send 0x00 then 0xFF with tx_valid held -> 0x00 frame, exactly 1 idle-high cycle, then the 0xFF frame (0, eight 1s, 1).
REQ-029 Ignore while busy: change tx_data to 0x3C mid-frame of 0x81 -> the serial data still reads 0x81; 0x3C is sent only if it is still valid at the next accepting edge.
REQ-030 Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx_out=1 and tx_busy=0 at that edge; after release, tx_out stays 1 until a new accept.
REQ-031 Boundary divider: CLKS_PER_BIT=2, send 0x55 -> each bit exactly 2 cycles; frame length 20 cycles.
REQ-032 Post-reset: hold rst_n=0 for 3 cycles with tx_valid=1 -> no start bit; after release, the first edge shows tx_ready=1, and the start bit begins on the next edge.
